// File: rtl/bcd_display_driver.sv
// Samples a binary value on request, converts it to BCD one bit per clock (double dabble),
// and scans the result onto a common-anode 7-segment display with leading-zero blanking.
module bcd_display_driver #(
  parameter int W           = 16,
  parameter int DIGITS      = 5,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [W-1:0]          value,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(W);
  localparam logic [PW-1:0] PRE_MAX  = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [W-1:0]    shift_reg;
  logic [BW-1:0]   work;
  logic [BW-1:0]   adj;
  logic [CW-1:0]   bit_cnt;
  logic [PW-1:0]   presc;
  logic [IW-1:0]   idx;
  logic [DIGITS:0] lz;
  logic [3:0]      cur_nib;
  logic            cur_blank;
  logic [DIGITS-1:0] an_next;
  logic [6:0]      seg_next;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Add-3 correction applied before every shift so each nibble stays a valid decimal digit.
  always_comb begin
    adj = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      work      <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= value;
            work      <= '0;
            bit_cnt   <= CNT_INIT;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          work      <= {adj[BW-2:0], shift_reg[W-1]};
          shift_reg <= shift_reg << 1;
          bit_cnt   <= bit_cnt - 1'b1;
          if (bit_cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          bcd   <= work;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRE_MAX) begin
      presc <= '0;
      idx   <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // lz[i] is set when nibble i and every nibble above it are zero.
  always_comb begin
    lz[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz[i] = lz[i+1] && (bcd[4*i +: 4] == 4'd0);
    end
  end

  always_comb begin
    cur_nib   = 4'd0;
    cur_blank = 1'b0;
    an_next   = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib    = bcd[4*i +: 4];
        cur_blank  = (i != 0) && lz[i];
        an_next[i] = 1'b0;
      end
    end
    seg_next = cur_blank ? 7'b1111111 : decode(cur_nib);
  end

  // an and seg share one register stage so a digit switch never shows the neighbour's pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= ~DIGITS'(1);
      seg <= 7'b1000000;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Self-checking bench for bcd_display_driver: vector table, randomized conversions against a
// decimal-arithmetic model, and hand-written sequences for back-to-back, ignored start and reset.
module tb_bcd_display_driver;

  localparam int W = 16;
  localparam int DIGITS = 5;
  localparam int REFRESH_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic [4:0]  an;
  logic [6:0]  seg;

  int n_checks = 0;
  int n_fail = 0;

  bcd_display_driver #(.W(W), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clk(clk), .reset(reset), .value(value), .start(start),
    .busy(busy), .done(done), .bcd(bcd), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] value;
    logic [19:0] exp_bcd;
  } vec_t;

  vec_t vecs[8];
  logic [6:0] seg_tab[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] model_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] model_seg(input int unsigned v, input int d);
    int unsigned p;
    p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    if (d > 0 && v < p) return 7'b1111111;
    return seg_tab[(v / p) % 10];
  endfunction

  task automatic convert(input logic [15:0] v, input bit poke);
    int n;
    bit busy_ok;
    @(negedge clk);
    value = v;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    value = 16'($urandom);
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (poke && n == 5) begin
        start = 1'b1;
        value = ~v;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("latency", n, 17);
    chk("busy_during", {31'd0, busy_ok}, 1);
    chk("busy_at_done", {31'd0, busy}, 0);
    chk("bcd_model", {12'd0, bcd}, {12'd0, model_bcd(v)});
    @(negedge clk);
    chk("done_width", {31'd0, done}, 0);
    chk("idle_after", {31'd0, busy}, 0);
  endtask

  task automatic check_display(input int unsigned v);
    logic [4:0] seen;
    int d;
    seen = '0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      chk("an_onehot", $countones(~an), 1);
      d = 0;
      for (int i = 0; i < DIGITS; i++) if (!an[i]) d = i;
      seen[d] = 1'b1;
      chk("seg_digit", {25'd0, seg}, {25'd0, model_seg(v, d)});
    end
    chk("digits_seen", {27'd0, seen}, 32'h1f);
  endtask

  task automatic reset_and_scan(input int cycles);
    int e;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_bcd", {12'd0, bcd}, 0);
    chk("rst_an", {27'd0, an}, 32'h1e);
    chk("rst_seg", {25'd0, seg}, 32'h40);
    reset = 1'b0;
    for (int j = 1; j <= cycles; j++) begin
      @(negedge clk);
      e = ((j - 1) / REFRESH_DIV) % DIGITS;
      chk("scan_an", {27'd0, an}, {27'd0, ~(5'b00001 << e)});
      chk("scan_seg", {25'd0, seg}, {25'd0, model_seg(0, e)});
      chk("no_done", {31'd0, done}, 0);
    end
  endtask

  initial begin
    int t1, t2, t3, cyc, bound;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    vecs[0] = '{16'd12345, 20'h12345};
    vecs[1] = '{16'd7,     20'h00007};
    vecs[2] = '{16'd65535, 20'h65535};
    vecs[3] = '{16'd100,   20'h00100};
    vecs[4] = '{16'd0,     20'h00000};
    vecs[5] = '{16'd9999,  20'h09999};
    vecs[6] = '{16'd10000, 20'h10000};
    vecs[7] = '{16'd59049, 20'h59049};

    reset_and_scan(45);

    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].value, 1'b0);
      chk("vec_bcd", {12'd0, bcd}, {12'd0, vecs[i].exp_bcd});
    end

    convert(16'd7, 1'b0);
    check_display(7);
    convert(16'd65535, 1'b0);
    check_display(65535);
    convert(16'd100, 1'b0);
    check_display(100);

    convert(16'd4321, 1'b1);
    chk("poke_ignored", {12'd0, bcd}, 32'h04321);

    // start held high: conversions repeat every W+2 cycles
    @(negedge clk);
    value = 16'd2024;
    start = 1'b1;
    cyc = 0;
    t1 = -1; t2 = -1; t3 = -1;
    bound = 0;
    while (t3 < 0 && bound < 200) begin
      @(negedge clk);
      cyc++;
      bound++;
      if (done) begin
        if (t1 < 0) t1 = cyc;
        else if (t2 < 0) t2 = cyc;
        else t3 = cyc;
      end
    end
    chk("b2b_gap1", t2 - t1, 18);
    chk("b2b_gap2", t3 - t2, 18);
    chk("b2b_bcd", {12'd0, bcd}, 32'h02024);
    start = 1'b0;
    bound = 0;
    while (busy && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    chk("b2b_drain", {31'd0, busy}, 0);

    // reset five cycles into a conversion of 9999
    @(negedge clk);
    value = 16'd9999;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset_and_scan(40);

    for (int i = 0; i < 20; i++) begin
      convert(16'($urandom_range(0, 65535)), 1'b0);
    end
    convert(16'($urandom_range(0, 65535)), 1'b0);
    check_display(int'(bcd[3:0]) + 10 * int'(bcd[7:4]) + 100 * int'(bcd[11:8])
                  + 1000 * int'(bcd[15:12]) + 10000 * int'(bcd[19:16]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
